// File: rtl/pulse_burst_sched.sv
// Burst table sequencer for the OSERDES pulse generator (clk_div domain).
// Plays table entries in order, drives the generator config and start,
// waits for done with a timeout, and optionally loops the sequence.
module pulse_burst_sched #(
  parameter int          DEPTH       = 8,
  parameter int          AW          = $clog2(DEPTH),
  parameter int          START_HOLD  = 4,
  parameter logic [31:0] TIMEOUT_CYC = 32'd125_000_000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [37:0]   cfg_wdata,
  input  logic [AW:0]   seq_len_i,
  input  logic [7:0]    loops_i,
  input  logic          run_i,
  input  logic          abort_i,
  input  logic          done_i,
  output logic [10:0]   pg_width_o,
  output logic [10:0]   pg_num_o,
  output logic [15:0]   pg_gap_o,
  output logic          pg_start_o,
  output logic          pg_rst_o,
  output logic          busy_o,
  output logic          seq_done_o,
  output logic          aborted_o,
  output logic          timeout_o,
  output logic [AW-1:0] cur_idx_o,
  output logic [7:0]    loop_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT, S_NEXT, S_DONE, S_ERR
  } state_t;

  // Handshake with the generator: pg_*_o config is stable from LOAD until
  // the next LOAD; pg_start_o is a level held START_HOLD cycles; done_i is a
  // one-cycle pulse that is only honoured in WAIT.

  state_t      r_state;
  logic [37:0] r_table [DEPTH];
  logic [AW:0] r_seq_len;
  logic [7:0]  r_loops;
  logic [AW-1:0] r_idx;
  logic [7:0]  r_loop;
  logic [3:0]  r_hold;
  logic [31:0] r_to;
  logic        r_rst_hold;
  logic [10:0] r_pg_width;
  logic [10:0] r_pg_num;
  logic [15:0] r_pg_gap;
  logic        r_pg_start;
  logic        r_pg_rst;
  logic        r_seq_done;
  logic        r_aborted;
  logic        r_timeout;

  logic [37:0] w_entry;
  logic        w_skip;
  logic        w_last;
  logic [7:0]  w_loop_inc;

  assign w_entry    = r_table[r_idx];
  assign w_skip     = (w_entry[37:27] == 11'd0) || (w_entry[26:16] == 11'd0);
  assign w_last     = ({1'b0, r_idx} == (r_seq_len - (AW+1)'(1)));
  assign w_loop_inc = (r_loop == 8'hFF) ? 8'hFF : (r_loop + 8'd1);

  // Table storage: written only while idle, never reset.
  always_ff @(posedge clk) begin
    if (rst_n && cfg_we && (r_state == S_IDLE))
      r_table[cfg_addr] <= cfg_wdata;
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_seq_len  <= '0;
      r_loops    <= '0;
      r_idx      <= '0;
      r_loop     <= '0;
      r_hold     <= '0;
      r_to       <= '0;
      r_rst_hold <= 1'b0;
      r_pg_width <= '0;
      r_pg_num   <= '0;
      r_pg_gap   <= '0;
      r_pg_start <= 1'b0;
      r_pg_rst   <= 1'b0;
      r_seq_done <= 1'b0;
      r_aborted  <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_seq_done <= 1'b0;
      r_aborted  <= 1'b0;
      // Generator reset is a 2-cycle stretch: r_rst_hold marks the first cycle.
      if (r_rst_hold) r_rst_hold <= 1'b0;
      else            r_pg_rst   <= 1'b0;
      if ((r_state == S_START) || (r_state == S_WAIT)) r_to <= r_to + 32'd1;

      if (abort_i && (r_state != S_IDLE) && (r_state != S_ERR)) begin
        r_state    <= S_IDLE;
        r_aborted  <= 1'b1;
        r_pg_start <= 1'b0;
        r_pg_rst   <= 1'b1;
        r_rst_hold <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (run_i) begin
              r_seq_len <= seq_len_i;
              r_loops   <= loops_i;
              r_idx     <= '0;
              r_loop    <= '0;
              r_timeout <= 1'b0;
              r_state   <= (seq_len_i == '0) ? S_DONE : S_LOAD;
            end
          end
          S_LOAD: begin
            r_pg_width <= w_entry[37:27];
            r_pg_num   <= w_entry[26:16];
            r_pg_gap   <= w_entry[15:0];
            if (w_skip) begin
              r_state <= S_NEXT;
            end else begin
              r_pg_start <= 1'b1;
              r_hold     <= '0;
              r_to       <= '0;
              r_state    <= S_START;
            end
          end
          S_START: begin
            if (r_hold == 4'(START_HOLD - 1)) begin
              r_pg_start <= 1'b0;
              r_state    <= S_WAIT;
            end else begin
              r_hold <= r_hold + 4'd1;
            end
          end
          S_WAIT: begin
            if (done_i) begin
              r_state <= S_NEXT;
            end else if (r_to >= (TIMEOUT_CYC - 32'd1)) begin
              r_timeout  <= 1'b1;
              r_pg_rst   <= 1'b1;
              r_rst_hold <= 1'b1;
              r_state    <= S_ERR;
            end
          end
          S_NEXT: begin
            if (!w_last) begin
              r_idx   <= r_idx + AW'(1);
              r_state <= S_LOAD;
            end else begin
              r_loop <= w_loop_inc;
              if ((r_loops != 8'd0) && (w_loop_inc == r_loops)) begin
                r_state <= S_DONE;
              end else begin
                r_idx   <= '0;
                r_state <= S_LOAD;
              end
            end
          end
          S_DONE: begin
            r_seq_done <= 1'b1;
            r_state    <= S_IDLE;
          end
          S_ERR: begin
            if (!r_rst_hold) r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign pg_width_o = r_pg_width;
  assign pg_num_o   = r_pg_num;
  assign pg_gap_o   = r_pg_gap;
  assign pg_start_o = r_pg_start;
  assign pg_rst_o   = r_pg_rst;
  assign busy_o     = (r_state != S_IDLE);
  assign seq_done_o = r_seq_done;
  assign aborted_o  = r_aborted;
  assign timeout_o  = r_timeout;
  assign cur_idx_o  = r_idx;
  assign loop_cnt_o = r_loop;

endmodule

// File: tb/tb_pulse_burst_sched.sv
// Bench for pulse_burst_sched: directed scenarios followed by randomized
// tables checked against a burst-list reference model.
module tb_pulse_burst_sched;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int SH    = 4;
  localparam int TOC   = 100;

  logic          clk;
  logic          rst_n;
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [37:0]   cfg_wdata;
  logic [AW:0]   seq_len_i;
  logic [7:0]    loops_i;
  logic          run_i;
  logic          abort_i;
  logic          done_i;
  logic [10:0]   pg_width_o;
  logic [10:0]   pg_num_o;
  logic [15:0]   pg_gap_o;
  logic          pg_start_o;
  logic          pg_rst_o;
  logic          busy_o;
  logic          seq_done_o;
  logic          aborted_o;
  logic          timeout_o;
  logic [AW-1:0] cur_idx_o;
  logic [7:0]    loop_cnt_o;

  logic [54:0] all_outs;
  assign all_outs = {pg_width_o, pg_num_o, pg_gap_o, pg_start_o, pg_rst_o, busy_o,
                     seq_done_o, aborted_o, timeout_o, cur_idx_o, loop_cnt_o};

  pulse_burst_sched #(
    .DEPTH(DEPTH), .AW(AW), .START_HOLD(SH), .TIMEOUT_CYC(32'd100)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .seq_len_i(seq_len_i), .loops_i(loops_i),
    .run_i(run_i), .abort_i(abort_i), .done_i(done_i),
    .pg_width_o(pg_width_o), .pg_num_o(pg_num_o), .pg_gap_o(pg_gap_o),
    .pg_start_o(pg_start_o), .pg_rst_o(pg_rst_o), .busy_o(busy_o),
    .seq_done_o(seq_done_o), .aborted_o(aborted_o), .timeout_o(timeout_o),
    .cur_idx_o(cur_idx_o), .loop_cnt_o(loop_cnt_o)
  );

  // Clock and edge counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Scoreboard state
  int n_vec = 0;
  int n_err = 0;
  logic [37:0] tbl [DEPTH];
  logic [37:0] exp_q[$];
  logic [37:0] got_q[$];
  int len_q[$];
  int rise_q[$];
  int done_set_q[$];
  int rst_rise_q[$];
  int rst_len_q[$];
  int seq_done_n = 0;
  int seq_done_last = 0;
  int aborted_n = 0;
  int start_cnt = 0;
  int run_edge = 0;
  bit gen_en = 0;
  int gen_delay = 10;
  bit done_req = 0;

  // Output monitor plus behavioural generator (done after gen_delay cycles)
  initial begin
    int cd;
    bit cd_act;
    bit prev_s;
    bit prev_r;
    int slen;
    int rlen;
    cd = 0; cd_act = 0; prev_s = 0; prev_r = 0; slen = 0; rlen = 0;
    done_i = 1'b0;
    forever begin
      @(negedge clk);
      done_i = 1'b0;
      if (!gen_en) cd_act = 0;
      if (done_req) begin
        done_i = 1'b1;
        done_req = 0;
        done_set_q.push_back(cyc);
      end else if (cd_act) begin
        if (cd <= 1) begin
          done_i = 1'b1;
          cd_act = 0;
          done_set_q.push_back(cyc);
        end else begin
          cd--;
        end
      end
      if ((pg_start_o === 1'b1) && !prev_s) begin
        got_q.push_back({pg_width_o, pg_num_o, pg_gap_o});
        rise_q.push_back(cyc);
        slen = 1;
        start_cnt++;
        if (gen_en) begin
          cd = gen_delay;
          cd_act = 1;
        end
      end else if (pg_start_o === 1'b1) begin
        slen++;
      end
      if ((pg_start_o !== 1'b1) && prev_s) len_q.push_back(slen);
      if ((pg_rst_o === 1'b1) && !prev_r) begin
        rst_rise_q.push_back(cyc);
        rlen = 1;
      end else if (pg_rst_o === 1'b1) begin
        rlen++;
      end
      if ((pg_rst_o !== 1'b1) && prev_r) rst_len_q.push_back(rlen);
      if (seq_done_o === 1'b1) begin
        seq_done_n++;
        seq_done_last = cyc;
      end
      if (aborted_o === 1'b1) aborted_n++;
      prev_s = (pg_start_o === 1'b1);
      prev_r = (pg_rst_o === 1'b1);
    end
  end

  // Driver and checker tasks
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    got_q.delete(); len_q.delete(); rise_q.delete();
    done_set_q.delete(); rst_rise_q.delete(); rst_len_q.delete();
  endtask

  task automatic write_raw(input int addr, input logic [37:0] data);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_addr = AW'(addr); cfg_wdata = data;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic write_entry(input int addr, input int w, input int n, input int g);
    logic [37:0] d;
    d = {11'(w), 11'(n), 16'(g)};
    write_raw(addr, d);
    tbl[addr] = d;
  endtask

  task automatic run(input int sl, input int lp);
    @(posedge clk); #1;
    seq_len_i = (AW+1)'(sl); loops_i = 8'(lp); run_i = 1'b1;
    @(posedge clk); #1;
    run_edge = cyc;
    run_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k;
    k = 0;
    while ((busy_o !== 1'b0) && (k < budget)) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 64'(k < budget), 64'd1);
    step(2);
  endtask

  task automatic wait_start_done(input string tag, input int budget);
    int k;
    k = 0;
    while ((len_q.size() < 1) && (k < budget)) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 64'(k < budget), 64'd1);
  endtask

  // Reference model: the bursts a run should issue, in order
  function automatic void build_exp(input int sl, input int lp);
    logic [37:0] e;
    exp_q.delete();
    for (int l = 0; l < lp; l++)
      for (int i = 0; i < sl; i++) begin
        e = tbl[i];
        if ((e[37:27] != 11'd0) && (e[26:16] != 11'd0)) exp_q.push_back(e);
      end
  endfunction

  task automatic cmp_bursts(input string tag);
    chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      chk({tag, "_cfg"}, (i < got_q.size()) ? 64'(got_q[i]) : 64'hDEAD, 64'(exp_q[i]));
      chk({tag, "_hold"}, (i < len_q.size()) ? 64'(len_q[i]) : 64'hDEAD, 64'(SH));
    end
  endtask

  // Directed and randomized sequence
  initial begin
    int sd0, sc0, ab0, k, sl, lp, w, n;
    logic [AW-1:0] idx_a, idx_b, idx_c;
    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    seq_len_i = '0; loops_i = '0; run_i = 1'b0; abort_i = 1'b0;
    step(3);
    @(negedge clk);
    chk("reset_outputs", 64'(all_outs), 64'd0);
    step(1);
    rst_n = 1'b1;
    step(1);
    clear_mon();

    // Two-entry sequence, generator answers after 50 cycles
    write_entry(0, 20, 3, 5);
    write_entry(1, 7, 1, 2);
    clear_mon(); gen_en = 1; gen_delay = 50; sd0 = seq_done_n;
    run(2, 1);
    @(negedge clk);
    chk("t1_busy_after_run", 64'(busy_o), 64'd1);
    write_raw(0, {11'd99, 11'd9, 16'd9});
    wait_idle("t1_finish", 1000);
    build_exp(2, 1);
    cmp_bursts("t1");
    chk("t1_first_rise", 64'(rise_q[0] - run_edge), 64'd1);
    chk("t1_chain_rise", 64'(rise_q[1] - done_set_q[0]), 64'd3);
    chk("t1_seq_done", 64'(seq_done_n - sd0), 64'd1);
    chk("t1_loop_cnt", 64'(loop_cnt_o), 64'd1);
    chk("t1_busy_end", 64'(busy_o), 64'd0);

    // Write during busy must have been dropped
    clear_mon();
    run(1, 1);
    wait_idle("t1b_finish", 1000);
    build_exp(1, 1);
    cmp_bursts("t1b_table_kept");

    // Empty sequence
    clear_mon(); sd0 = seq_done_n; sc0 = start_cnt;
    run(0, 1);
    wait_idle("t2_finish", 20);
    chk("t2_seq_done_time", 64'(seq_done_last - run_edge), 64'd1);
    chk("t2_seq_done_once", 64'(seq_done_n - sd0), 64'd1);
    chk("t2_no_start", 64'(start_cnt - sc0), 64'd0);

    // Skipped first entry
    write_entry(0, 15, 0, 8);
    write_entry(1, 33, 4, 12);
    clear_mon(); gen_delay = 20;
    run(2, 1);
    @(negedge clk); idx_a = cur_idx_o;
    @(negedge clk); idx_b = cur_idx_o;
    @(negedge clk); idx_c = cur_idx_o;
    chk("t3_idx_load0", 64'(idx_a), 64'd0);
    chk("t3_idx_next0", 64'(idx_b), 64'd0);
    chk("t3_idx_load1", 64'(idx_c), 64'd1);
    wait_idle("t3_finish", 500);
    build_exp(2, 1);
    cmp_bursts("t3");
    chk("t3_rise_time", 64'(rise_q[0] - run_edge), 64'd3);

    // Timeout
    write_entry(0, 5, 2, 1);
    clear_mon(); gen_en = 0; sd0 = seq_done_n;
    run(1, 1);
    wait_idle("t4_finish", 400);
    chk("t4_err_time", 64'(rst_rise_q[0] - rise_q[0]), 64'(TOC));
    chk("t4_rst_len", 64'(rst_len_q[0]), 64'd2);
    chk("t4_timeout_set", 64'(timeout_o), 64'd1);
    chk("t4_no_seq_done", 64'(seq_done_n - sd0), 64'd0);
    step(10);
    chk("t4_timeout_sticky", 64'(timeout_o), 64'd1);
    run(0, 1);
    @(negedge clk);
    chk("t4_timeout_cleared", 64'(timeout_o), 64'd0);
    wait_idle("t4b_finish", 20);

    // Endless loop, abort after the third done
    clear_mon(); gen_en = 1; gen_delay = 10; ab0 = aborted_n;
    run(1, 0);
    k = 0;
    while ((loop_cnt_o !== 8'd3) && (k < 1000)) begin
      @(negedge clk);
      k++;
    end
    chk("t5_three_loops", 64'(k < 1000), 64'd1);
    @(posedge clk); #1;
    abort_i = 1'b1;
    @(posedge clk); #1;
    abort_i = 1'b0; gen_en = 0;
    @(negedge clk);
    chk("t5_aborted", 64'(aborted_o), 64'd1);
    chk("t5_busy", 64'(busy_o), 64'd0);
    chk("t5_start_low", 64'(pg_start_o), 64'd0);
    chk("t5_rst_high", 64'(pg_rst_o), 64'd1);
    chk("t5_loop_cnt", 64'(loop_cnt_o), 64'd3);
    step(4);
    chk("t5_abort_once", 64'(aborted_n - ab0), 64'd1);
    chk("t5_rst_len", 64'(rst_len_q[rst_len_q.size()-1]), 64'd2);

    // Abort and done in the same cycle
    clear_mon(); gen_en = 0;
    run(1, 0);
    wait_start_done("t6_start", 100);
    step(2);
    abort_i = 1'b1; done_req = 1;
    @(posedge clk); #1;
    abort_i = 1'b0;
    @(negedge clk);
    chk("t6_abort_wins", 64'(aborted_o), 64'd1);
    chk("t6_busy", 64'(busy_o), 64'd0);
    chk("t6_loop_cnt", 64'(loop_cnt_o), 64'd0);
    step(4);

    // Reset in the middle of WAIT
    clear_mon();
    run(1, 1);
    wait_start_done("t7_start", 100);
    step(3);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("t7_reset_outputs", 64'(all_outs), 64'd0);
    rst_n = 1'b1;
    step(2);

    // Randomized tables and run parameters
    for (int r = 0; r < 6; r++) begin
      for (int a = 0; a < DEPTH; a++) begin
        w = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 2047));
        n = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 2047));
        write_entry(a, w, n, int'($urandom_range(0, 65535)));
      end
      sl = int'($urandom_range(1, DEPTH));
      lp = int'($urandom_range(1, 3));
      gen_delay = int'($urandom_range(5, 40));
      gen_en = 1;
      clear_mon(); sd0 = seq_done_n;
      run(sl, lp);
      write_raw(int'($urandom_range(0, DEPTH-1)), 38'($urandom));
      wait_idle("rnd_finish", 5000);
      build_exp(sl, lp);
      cmp_bursts("rnd");
      chk("rnd_loop_cnt", 64'(loop_cnt_o), 64'(lp));
      chk("rnd_seq_done", 64'(seq_done_n - sd0), 64'd1);
    end
    gen_en = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pulse_burst_sched.md
# pulse_burst_sched

Sequencer for the OSERDES pulse generator. It holds a small table of burst configurations (pulse width, pulse count, gap) and plays them in order, optionally looping. For each entry it drives the generator's config inputs and start, waits for done, and enforces a timeout. It runs in the `clk_div` domain alongside the generator and is written by the PS register block.

## Interface
Parameters:
- `DEPTH`, 8: table entries, power of two, 2..64
- `AW`, `$clog2(DEPTH)`: table address width
- `START_HOLD`, 4: cycles `pg_start_o` is held high, 2..15
- `TIMEOUT_CYC`, 32'd125_000_000: max cycles from start assertion to `done_i` (1 s at 125 MHz)

Ports:
- `clk` in 1: `clk_div` domain clock (125 MHz)
- `rst_n` in 1: synchronous, active-low reset
- `cfg_we` in 1: table write strobe
- `cfg_addr` in AW: table write address
- `cfg_wdata` in 38: {width[37:27], num[26:16], gap_us[15:0]}
- `seq_len_i` in AW+1: entries to play, 0..DEPTH, sampled at run
- `loops_i` in 8: sequence repetitions, 0 = until abort, sampled at run
- `run_i` in 1: start request, level, accepted only in IDLE
- `abort_i` in 1: stop request
- `done_i` in 1: generator done pulse
- `pg_width_o` out 11: generator pulse width
- `pg_num_o` out 11: generator pulse count
- `pg_gap_o` out 16: generator gap in µs
- `pg_start_o` out 1: generator start
- `pg_rst_o` out 1: generator reset, active high
- `busy_o` out 1: high whenever state ≠ IDLE
- `seq_done_o` out 1: 1-cycle pulse on normal completion
- `aborted_o` out 1: 1-cycle pulse on abort
- `timeout_o` out 1: sticky error flag, cleared by the next accepted run
- `cur_idx_o` out AW: entry currently playing
- `loop_cnt_o` out 8: completed loops

## Operation
- Reset (`rst_n`=0 at a clock edge): state IDLE, all outputs 0, idx and loop counter 0. Table contents are not reset.
- Table writes are accepted only in IDLE. A `cfg_we` while busy is dropped.
- States: IDLE, LOAD, START, WAIT, NEXT, DONE, ERR.
- IDLE:
  - On `run_i`=1: latch `seq_len_i`/`loops_i`, set idx=0 and loop=0, clear `timeout_o`.
  - If seq_len=0, go to DONE; otherwise go to LOAD.
- LOAD:
  - Register the table entry at idx onto `pg_*_o`.
  - If width=0 or num=0, the entry is skipped: go to NEXT with no start issued.
  - Otherwise go to START.
- START:
  - `pg_start_o`=1 for exactly START_HOLD cycles, then go to WAIT.
  - Timeout counter clears on START entry.
- WAIT:
  - `pg_start_o`=0.
  - `done_i`=1 → NEXT.
  - Timeout counter reaches TIMEOUT_CYC−1 → ERR.
  - `done_i` is ignored in every other state.
- NEXT:
  - If idx≠seq_len−1: idx+1, go to LOAD.
  - Else: loop+1 (saturating at 255). If loops≠0 and the new loop count equals loops → DONE; otherwise idx=0 → LOAD.
- DONE: `seq_done_o`=1 for one cycle, go to IDLE.
- ERR:
  - `timeout_o`=1 (sticky).
  - `pg_rst_o`=1 for 2 cycles, then go to IDLE.
- Abort:
  - `abort_i`=1 in any non-IDLE state except ERR → IDLE on the next edge.
  - That cycle: `aborted_o`=1, `pg_start_o`=0, and `pg_rst_o`=1 for 2 cycles, counted from the abort edge.
  - Abort has priority over `done_i` and over timeout in the same cycle.
- `pg_*_o` config outputs change only in LOAD and hold until the next LOAD, so the generator never sees config move mid-burst.
- `cur_idx_o`=idx and `loop_cnt_o`=loop at all times.

## Timing
- `run_i` sampled at edge T0 → LOAD at T1. `pg_*_o` are valid and `pg_start_o` rises at T2, staying high T2..T2+START_HOLD−1.
- Skipped entry costs 2 cycles (LOAD, NEXT). Chained entries cost LOAD+START_HOLD+wait+NEXT.
- `done_i` sampled at Tn in WAIT → NEXT at Tn+1, and the next entry's `pg_start_o` rises at Tn+3.
- `run_i` held high across DONE re-triggers a run 1 cycle after IDLE is re-entered.
- Timeout: ERR is entered TIMEOUT_CYC cycles after `pg_start_o` rises if no done arrives.

## Test plan
- Two entries {w=20,n=3,g=5}, {w=7,n=1,g=2}, seq_len=2, loops=1, with a behavioural generator model returning done 50 cycles after start → two start pulses of 4 cycles each with the correct config on each, `seq_done_o` once, `loop_cnt_o`=1, `busy_o` low after.
- seq_len=0, run → `seq_done_o` at T2, no `pg_start_o`.
- Entry 0 with num=0, entry 1 valid → only one start issued, and it carries entry-1 config; `cur_idx_o` shows 0 then 1.
- TIMEOUT_CYC=100, done never returned → ERR 100 cycles after the start edge, `pg_rst_o` high for 2 cycles, `timeout_o` sticky until the next run.
- loops=0, one entry, abort after the 3rd done → `aborted_o` pulse, `pg_rst_o` high for 2 cycles, `loop_cnt_o`=3; abort and done in the same cycle → abort wins.
- `cfg_we` to address 0 while busy → table unchanged on the next run; `rst_n`=0 mid-WAIT → all outputs 0 next cycle.
